spi_flash_responder: RTL
========================

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 Parameter: ADDR_W, 24, address width in bits; the address counter wraps modulo 2^ADDR_W.
REQ-002 Parameter: JEDEC_ID, 24'hEF4016, three-byte ID returned by command 0x9F, MSB first.
REQ-003 clk  input  1  system clock; SCLK is oversampled on this clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 csb  input  1  SPI chip select, active-low.
REQ-006 sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-007 mosi  input  1  SPI data from the initiator (io0).
REQ-008 miso  output  1  SPI data to the initiator (io1).
REQ-009 miso_oe  output  1  output enable for miso.
REQ-010 mem_rd  output  1  single-cycle memory read strobe.
REQ-011 mem_addr  output  ADDR_W  memory read byte address.
REQ-012 mem_rdata  input  8  read data, valid exactly 1 clk after mem_rd.
REQ-013 busy  output  1  high while csb is low (synchronized).
REQ-014 cmd_err  output  1  one-cycle pulse when an unsupported opcode is received.

Function
REQ-015 csb, sclk and mosi each pass through a 2-flop synchronizer; all logic uses the synchronized copies only.
REQ-016 A rising edge is sync_sclk going 0->1 with sync_csb=0; a falling edge is sync_sclk going 1->0 with sync_csb=0.
REQ-017 sclk frequency is at most clk/8; behaviour is undefined above this rate.
REQ-018 Rising edges shift sync_mosi into the receive register, MSB first; falling edges shift the transmit register, MSB first, onto miso.
REQ-019 States: IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-020 IDLE->CMD occurs on the sync_csb falling edge; bit and byte counters clear on this transition.
REQ-021 CMD: after 8 rising edges the opcode is decoded: 0x03->ADDR; 0x9F->ID; any other value->IGNORE and cmd_err pulses for 1 clk.
REQ-022 ADDR: the block collects ADDR_W bits, MSB first; the upper 24-ADDR_W bits are discarded when ADDR_W<24, so exactly 24 address bits are always clocked.
REQ-023 ADDR->DATA transition, in the clk after the 24th address rising edge: mem_rd=1, mem_addr=received address, address counter = address+1.
REQ-024 mem_rdata is loaded into the transmit register 1 clk after mem_rd.
REQ-025 The first falling edge after the load drives bit 7; the drive completes before that falling edge.
REQ-026 DATA: on the 8th rising edge of each byte, mem_rd pulses with mem_addr=address counter and the counter increments.
REQ-027 DATA: the fetched byte is loaded so that its bit 7 appears on the next falling edge; the stream is unbounded.
REQ-028 Address wrap: the counter increments from 2^ADDR_W-1 to 0.
REQ-029 ID: the block transmits JEDEC_ID[23:16], [15:8], [7:0] on successive bytes, then repeats 0xFF bytes; the first bit is driven on the falling edge after the opcode's 8th rising edge.
REQ-030 IGNORE: the block discards all edges and keeps miso_oe=0 until csb rises.
REQ-031 miso_oe=1 only in DATA or ID; in every other state miso_oe=0 and miso=0.
REQ-032 sync_csb going high in any state returns the block to IDLE on the next clk.
REQ-033 On that return the block abandons any partial byte, clears the counters, drops miso_oe, and does not issue a further mem_rd.
REQ-034 mem_rd never asserts in IDLE, CMD, ID or IGNORE.
REQ-035 A rising and a falling sclk edge cannot occur in the same clk; if csb rises and an sclk edge occurs in the same clk, the deselect takes priority.

Reset
REQ-036 rst=1 forces state=IDLE, miso=0, miso_oe=0, mem_rd=0, mem_addr=0, busy=0, cmd_err=0, and clears the address counter, the shift registers and the synchronizer flops.
REQ-037 rst asserted mid-transaction aborts the transaction.
REQ-038 After rst, the block enters CMD only on a new csb falling edge; a csb that is already low at reset release is ignored until it goes high and then low again.

Verification
REQ-039 READ: csb low, send 0x03 then address 0x000010, then clock 16 bits with mem holding [0x10]=0xA5 and [0x11]=0x3C -> miso returns 0xA5 then 0x3C; mem_rd is strobed with addresses 0x10, 0x11 and 0x12.
REQ-040 JEDEC ID: send 0x9F, then clock 32 bits -> miso returns 0xEF, 0x40, 0x16, 0xFF.
REQ-041 Wrap: READ at address 0xFFFFFF, clock 2 bytes -> mem_addr sequence is 0xFFFFFF then 0x000000.
REQ-042 Bad opcode: send 0x05, then 16 more clocks -> cmd_err pulses once, miso_oe stays 0, and no mem_rd is issued.
REQ-043 Abort: csb rises after 4 data bits of a READ, then a new READ to address 0x20 -> the new stream starts with byte [0x20] and no stale bits appear.
REQ-044 Reset mid-DATA: assert rst for 1 clk during DATA -> all outputs are 0 next clk; while csb stays low, further sclk edges produce no response.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI (mode 0) serial-flash responder: answers READ (0x03) from an external byte memory
// and JEDEC ID (0x9F); everything runs on clk with SCLK/CSB/MOSI oversampled.
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csb,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_ID,
        S_IGNORE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2:0] w_async_in;
    logic [2:0] w_sync;
    assign w_async_in = {csb, sclk, mosi};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic r_meta;
        logic r_sync_bit;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_meta     <= 1'b0;
                r_sync_bit <= 1'b0;
            end else begin
                r_meta     <= w_async_in[gi];
                r_sync_bit <= r_meta;
            end
        end
        assign w_sync[gi] = r_sync_bit;
    end

    logic w_csb_s;
    logic w_sclk_s;
    logic w_mosi_s;
    assign w_csb_s  = w_sync[2];
    assign w_sclk_s = w_sync[1];
    assign w_mosi_s = w_sync[0];

    logic              r_csb_prev;
    logic              r_sclk_prev;
    logic [4:0]        r_bit_cnt;
    logic [22:0]       r_rx;
    logic [7:0]        r_tx;
    logic              r_miso;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_rd_d;
    logic [1:0]        r_id_idx;
    logic              r_cmd_err;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_csb_fall;
    logic [23:0] w_rx_next;
    logic        w_rd_first;
    logic        w_rd_next;
    logic        w_cmd_err_set;
    logic        w_id_start;
    logic        w_id_next;
    logic [7:0]  w_id_byte;

    // csb_prev resets low, so a csb already low at reset release never looks like a falling edge
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev & ~w_csb_s;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev & ~w_csb_s;
    assign w_csb_fall  = ~w_csb_s & r_csb_prev;
    assign w_rx_next   = {r_rx, w_mosi_s};

    always_comb begin
        w_id_byte = 8'hFF;
        case (r_id_idx)
            2'd1:    w_id_byte = JEDEC_ID[15:8];
            2'd2:    w_id_byte = JEDEC_ID[7:0];
            default: w_id_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_rd_first    = 1'b0;
        w_rd_next     = 1'b0;
        w_cmd_err_set = 1'b0;
        w_id_start    = 1'b0;
        w_id_next     = 1'b0;
        if (r_state != S_IDLE && w_csb_s) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_csb_fall) w_state_next = S_CMD;
                end
                S_CMD: begin
                    if (w_sclk_rise && r_bit_cnt == 5'd7) begin
                        case (w_rx_next[7:0])
                            8'h03: w_state_next = S_ADDR;
                            8'h9F: begin
                                w_state_next = S_ID;
                                w_id_start   = 1'b1;
                            end
                            default: begin
                                w_state_next  = S_IGNORE;
                                w_cmd_err_set = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_sclk_rise && r_bit_cnt == 5'd23) begin
                        w_state_next = S_DATA;
                        w_rd_first   = 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_sclk_rise && r_bit_cnt == 5'd7) w_rd_next = 1'b1;
                end
                S_ID: begin
                    if (w_sclk_rise && r_bit_cnt == 5'd7) w_id_next = 1'b1;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csb_prev  <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_addr_cnt  <= '0;
            r_rd_d      <= 1'b0;
            r_id_idx    <= '0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_csb_prev  <= w_csb_s;
            r_sclk_prev <= w_sclk_s;
            r_cmd_err   <= w_cmd_err_set;
            r_mem_rd    <= w_rd_first | w_rd_next;
            r_rd_d      <= r_mem_rd & (w_state_next == S_DATA);

            // ADDR counts all 24 address bits; byte-oriented states wrap every 8
            if (w_state_next != r_state || r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise) begin
                if (r_state == S_ADDR) r_bit_cnt <= r_bit_cnt + 5'd1;
                else                   r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
            end

            if (w_state_next == S_IDLE) begin
                r_rx <= '0;
            end else if (w_sclk_rise && (r_state == S_CMD || r_state == S_ADDR)) begin
                r_rx <= w_rx_next[22:0];
            end

            if (w_state_next == S_IDLE) begin
                r_addr_cnt <= '0;
            end else if (w_rd_first) begin
                r_mem_addr <= w_rx_next[ADDR_W-1:0];
                r_addr_cnt <= w_rx_next[ADDR_W-1:0] + 1'b1;
            end else if (w_rd_next) begin
                r_mem_addr <= r_addr_cnt;
                r_addr_cnt <= r_addr_cnt + 1'b1;
            end

            if (w_state_next == S_IDLE) begin
                r_tx     <= '0;
                r_miso   <= 1'b0;
                r_id_idx <= '0;
            end else if (w_id_start) begin
                r_tx     <= JEDEC_ID[23:16];
                r_id_idx <= 2'd1;
            end else if (w_id_next) begin
                r_tx <= w_id_byte;
                if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
            end else if (r_rd_d && r_state == S_DATA) begin
                r_tx <= mem_rdata;
            end else if (w_sclk_fall && (r_state == S_DATA || r_state == S_ID)) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end
    end

    assign miso_oe  = (r_state == S_DATA) || (r_state == S_ID);
    assign miso     = miso_oe & r_miso;
    assign busy     = (r_state != S_IDLE);
    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign cmd_err  = r_cmd_err;

endmodule
